// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the quotient fill pattern returned on divide-by-zero.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Replicated across the whole lo word when the divisor is zero
  localparam logic DIV_ZERO_LO = 1'b1;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter_unit_if.sv
// Request/response bundle between the EX stage (master) and the mul/div unit (slave).
interface muldiv_iter_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic               start_i;
  logic [1:0]         op_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               annul_i;
  logic               busy_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;
  logic               div_zero_o;

  modport master (
    output start_i, op_i, opdata1_i, opdata2_i, annul_i,
    input  busy_o, ready_o, result_o, div_zero_o
  );

  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
    output busy_o, ready_o, result_o, div_zero_o
  );

endinterface

// File: rtl/muldiv_div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not borrow.
module muldiv_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   partial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_c,
  output logic             q_bit_c
);

  logic [WIDTH:0] diff;

  // partial < 2*divisor always holds, so the top diff bit is exactly the borrow
  always_comb begin
    diff    = partial - {1'b0, divisor};
    q_bit_c = ~diff[WIDTH];
    rem_c   = q_bit_c ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage: shift-add multiply retiring
// MUL_BITS per cycle, restoring divide at one bit per cycle, {hi,lo} result.
module muldiv_iter_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 2
) (
  input  logic             clk,
  input  logic             resetn,
  muldiv_iter_unit_if.slave bus
);

  localparam int unsigned ITER_M = WIDTH / MUL_BITS;
  localparam int unsigned ITER_D = WIDTH;
  localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
  localparam int unsigned PW     = WIDTH + MUL_BITS;
  localparam int unsigned RW     = 2 * WIDTH;

  logic [1:0]       state_q,    state_nx;
  logic [CNT_W-1:0] cnt_q,      cnt_nx;
  logic [WIDTH-1:0] p_hi_q,     p_hi_nx;
  logic [WIDTH-1:0] p_lo_q,     p_lo_nx;
  logic [WIDTH-1:0] opnd_q,     opnd_nx;
  logic             neg_res_q,  neg_res_nx;
  logic             neg_rem_q,  neg_rem_nx;
  logic [RW-1:0]    result_q,   result_nx;
  logic             div_zero_q, div_zero_nx;
  logic             busy_q;
  logic             ready_q;

  // Operand magnitudes; abs of the most negative value wraps to itself as unsigned
  logic             sgn;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  always_comb begin
    sgn  = op_is_signed(bus.op_i);
    mag1 = (sgn && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    mag2 = (sgn && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
  end

  // Multiply step: {p_hi,p_lo} holds {partial product, unconsumed multiplier bits}
  logic [PW-1:0] mul_part;
  logic [RW-1:0] mul_prod;
  logic [RW-1:0] mul_final;

  always_comb begin
    mul_part  = PW'(p_hi_q) + PW'(opnd_q) * PW'(p_lo_q[MUL_BITS-1:0]);
    mul_prod  = RW'({mul_part, p_lo_q} >> MUL_BITS);
    mul_final = neg_res_q ? -mul_prod : mul_prod;
  end

  // Divide step: p_hi is the partial remainder, p_lo shifts dividend out / quotient in
  logic [WIDTH-1:0] div_rem;
  logic             div_qbit;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;

  muldiv_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .partial (WIDTH'(0) == WIDTH'(0) ? {p_hi_q, p_lo_q[WIDTH-1]} : {p_hi_q, p_lo_q[WIDTH-1]}),
    .divisor (opnd_q),
    .rem_c   (div_rem),
    .q_bit_c (div_qbit)
  );

  always_comb begin
    div_quo   = {p_lo_q[WIDTH-2:0], div_qbit};
    quo_final = neg_res_q ? -div_quo : div_quo;
    rem_final = neg_rem_q ? -div_rem : div_rem;
  end

  // Next-state and datapath update
  always_comb begin
    state_nx    = state_q;
    cnt_nx      = cnt_q;
    p_hi_nx     = p_hi_q;
    p_lo_nx     = p_lo_q;
    opnd_nx     = opnd_q;
    neg_res_nx  = neg_res_q;
    neg_rem_nx  = neg_rem_q;
    result_nx   = result_q;
    div_zero_nx = div_zero_q;

    if (bus.annul_i) begin
      state_nx = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            neg_res_nx = sgn & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
            neg_rem_nx = sgn & bus.opdata1_i[WIDTH-1];
            cnt_nx     = '0;
            p_hi_nx    = '0;
            if (op_is_div(bus.op_i)) begin
              p_lo_nx = mag1;
              opnd_nx = mag2;
              if (bus.opdata2_i == '0) begin
                result_nx   = {bus.opdata1_i, {WIDTH{DIV_ZERO_LO}}};
                div_zero_nx = 1'b1;
                state_nx    = ST_DONE;
              end else begin
                state_nx = ST_DIV;
              end
            end else begin
              p_lo_nx  = mag2;
              opnd_nx  = mag1;
              state_nx = ST_MUL;
            end
          end
        end
        ST_MUL: begin
          p_hi_nx = mul_prod[RW-1:WIDTH];
          p_lo_nx = mul_prod[WIDTH-1:0];
          cnt_nx  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER_M - 1)) begin
            result_nx   = mul_final;
            div_zero_nx = 1'b0;
            state_nx    = ST_DONE;
          end
        end
        ST_DIV: begin
          p_hi_nx = div_rem;
          p_lo_nx = div_quo;
          cnt_nx  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER_D - 1)) begin
            result_nx   = {rem_final, quo_final};
            div_zero_nx = 1'b0;
            state_nx    = ST_DONE;
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      p_hi_q     <= '0;
      p_lo_q     <= '0;
      opnd_q     <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_nx;
      cnt_q      <= cnt_nx;
      p_hi_q     <= p_hi_nx;
      p_lo_q     <= p_lo_nx;
      opnd_q     <= opnd_nx;
      neg_res_q  <= neg_res_nx;
      neg_rem_q  <= neg_rem_nx;
      result_q   <= result_nx;
      div_zero_q <= div_zero_nx;
      busy_q     <= (state_nx != ST_IDLE);
      ready_q    <= (state_nx == ST_DONE);
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.ready_o    = ready_q;
  assign bus.result_o   = result_q;
  assign bus.div_zero_o = div_zero_q;

endmodule
